// File: rtl/fechadura_pkg.sv
// Shared types and constants for the lock datapath: PIN packet layout,
// key codes and the PIN-entry state encoding.
package fechadura_pkg;

    localparam logic [3:0] DIGIT_BLANK = 4'hA;
    localparam logic [3:0] KEY_CLEAR   = 4'hB;
    localparam logic [3:0] KEY_ENTER   = 4'hC;

    // digit1 is the most recently typed digit, digit4 the oldest retained one.
    typedef struct packed {
        logic [3:0] digit4;
        logic [3:0] digit3;
        logic [3:0] digit2;
        logic [3:0] digit1;
        logic       status;
    } pinPac_t;

    typedef enum logic [1:0] {
        VAZIO   = 2'd0,
        ENTRADA = 2'd1,
        ENVIA   = 2'd2
    } pin_state_t;

    localparam pinPac_t PIN_IDLE = '{
        digit4: DIGIT_BLANK,
        digit3: DIGIT_BLANK,
        digit2: DIGIT_BLANK,
        digit1: DIGIT_BLANK,
        status: 1'b0
    };

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/contador_timeout.sv
// Inactivity counter: counts run cycles since the last restart and emits a
// one-cycle expire pulse on the cycle that would reach TIMEOUT_CYCLES.
module contador_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic run,
    output logic expire
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_q;

    // restart beats expiry so a key on the final idle cycle cancels the timeout
    assign expire = run && !restart && (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (restart || expire) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/montar_pin.sv
// Assembles keypad digits into a 4-digit PIN packet for verificar_senha,
// with clear/enter keys, enable lockout and an inactivity timeout.
module montar_pin
    import fechadura_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output pinPac_t    pin_out,
    output logic [2:0] n_digits,
    output logic       timeout_evt,
    output pin_state_t state_dbg
);

    // Handshake: key_valid is a one-cycle strobe with no back-pressure; a
    // key is consumed on the edge where key_valid=1 and enable=1. pin_out is
    // a push-only output: digits are meaningful only while status=1.

    localparam logic [3:0][3:0] BLANK_BUF = {4{DIGIT_BLANK}};

    logic [3:0][3:0] buf_q, buf_d;   // index 0 = digit1 (newest)
    logic [2:0]      count_q, count_d;
    pinPac_t         pin_q, pin_d;
    logic            status_prev_q;
    logic            evt_q, evt_d;
    pin_state_t      state_q, state_d;

    logic key_known;
    logic accepted;
    logic tmo_restart;
    logic tmo_run;
    logic tmo_expire;

    assign key_known = is_digit(key_code) || (key_code == KEY_CLEAR) || (key_code == KEY_ENTER);
    assign accepted  = enable && key_valid && key_known;

    assign tmo_restart = accepted || !enable || (count_q == 3'd0);
    assign tmo_run     = enable && (count_q != 3'd0);

    contador_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .restart(tmo_restart),
        .run    (tmo_run),
        .expire (tmo_expire)
    );

    always_comb begin
        buf_d        = buf_q;
        count_d      = count_q;
        pin_d        = pin_q;
        pin_d.status = 1'b0;
        evt_d        = 1'b0;
        state_d      = state_q;

        // Digits linger one cycle past the status pulse, then go blank.
        if (!pin_q.status && status_prev_q) begin
            pin_d.digit1 = DIGIT_BLANK;
            pin_d.digit2 = DIGIT_BLANK;
            pin_d.digit3 = DIGIT_BLANK;
            pin_d.digit4 = DIGIT_BLANK;
        end

        if (!enable) begin
            buf_d   = BLANK_BUF;
            count_d = 3'd0;
        end else if (accepted) begin
            if (is_digit(key_code)) begin
                buf_d   = {buf_q[2:0], key_code};
                count_d = (count_q < 3'd4) ? count_q + 3'd1 : 3'd4;
            end else if (key_code == KEY_CLEAR) begin
                buf_d   = BLANK_BUF;
                count_d = 3'd0;
            end else begin
                pin_d.digit1 = buf_q[0];
                pin_d.digit2 = buf_q[1];
                pin_d.digit3 = buf_q[2];
                pin_d.digit4 = buf_q[3];
                pin_d.status = 1'b1;
                buf_d        = BLANK_BUF;
                count_d      = 3'd0;
            end
        end else if (tmo_expire) begin
            buf_d   = BLANK_BUF;
            count_d = 3'd0;
            evt_d   = 1'b1;
        end

        if (pin_d.status) begin
            state_d = ENVIA;
        end else if (count_d != 3'd0) begin
            state_d = ENTRADA;
        end else begin
            state_d = VAZIO;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q         <= BLANK_BUF;
            count_q       <= 3'd0;
            pin_q         <= PIN_IDLE;
            status_prev_q <= 1'b0;
            evt_q         <= 1'b0;
            state_q       <= VAZIO;
        end else begin
            buf_q         <= buf_d;
            count_q       <= count_d;
            pin_q         <= pin_d;
            status_prev_q <= pin_q.status;
            evt_q         <= evt_d;
            state_q       <= state_d;
        end
    end

    assign pin_out     = pin_q;
    assign n_digits    = count_q;
    assign timeout_evt = evt_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_montar_pin.sv
// Self-checking bench for montar_pin: directed test-plan sequences plus
// randomized keypad traffic compared against a queue-based reference model.
module tb_montar_pin;
    import fechadura_pkg::*;

    localparam int unsigned T = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       key_valid;
    logic [3:0] key_code;
    pinPac_t    pin_out;
    logic [2:0] n_digits;
    logic       timeout_evt;
    pin_state_t state_dbg;

    int total = 0;
    int bad   = 0;

    // reference model state
    int      mq[$];      // buffered digits, oldest first, at most 4
    int      m_idle;
    pinPac_t m_pin;
    logic    m_evt;
    logic    m_was;      // status value of the preceding cycle

    montar_pin #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .pin_out    (pin_out),
        .n_digits   (n_digits),
        .timeout_evt(timeout_evt),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic pinPac_t blank_pin();
        pinPac_t p;
        p.digit1 = 4'hA;
        p.digit2 = 4'hA;
        p.digit3 = 4'hA;
        p.digit4 = 4'hA;
        p.status = 1'b0;
        return p;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_idle = 0;
        m_pin  = blank_pin();
        m_evt  = 1'b0;
        m_was  = 1'b0;
    endtask

    // digit_k = k-th most recent digit, blank if fewer were typed
    function automatic logic [3:0] recent(input int k);
        if (k <= mq.size()) return 4'(mq[mq.size() - k]);
        return 4'hA;
    endfunction

    task automatic model_step(input logic en, input logic kv, input logic [3:0] kc);
        logic acc;
        logic old_status;
        acc        = en && kv && (kc <= 4'd9 || kc == 4'hB || kc == 4'hC);
        old_status = m_pin.status;
        m_evt      = 1'b0;
        if (acc && kc == 4'hC) begin
            m_pin.digit1 = recent(1);
            m_pin.digit2 = recent(2);
            m_pin.digit3 = recent(3);
            m_pin.digit4 = recent(4);
            m_pin.status = 1'b1;
        end else begin
            m_pin.status = 1'b0;
            if (!old_status && m_was) m_pin = blank_pin();
        end
        m_was = old_status;

        if (!en) begin
            mq.delete();
            m_idle = 0;
        end else if (acc) begin
            m_idle = 0;
            if (kc <= 4'd9) begin
                mq.push_back(int'(kc));
                if (mq.size() > 4) void'(mq.pop_front());
            end else begin
                mq.delete();
            end
        end else if (mq.size() > 0) begin
            m_idle++;
            if (m_idle == int'(T)) begin
                mq.delete();
                m_idle = 0;
                m_evt  = 1'b1;
            end
        end else begin
            m_idle = 0;
        end
    endtask

    task automatic check_all();
        pin_state_t es;
        if (m_pin.status) es = ENVIA;
        else if (mq.size() > 0) es = ENTRADA;
        else es = VAZIO;
        check("pin_out", 32'(pin_out), 32'(m_pin));
        check("n_digits", 32'(n_digits), 32'(mq.size()));
        check("timeout_evt", 32'(timeout_evt), 32'(m_evt));
        check("state", 32'(state_dbg), 32'(es));
    endtask

    task automatic check_reset_values();
        check("rst_pin_out", 32'(pin_out), 32'(blank_pin()));
        check("rst_n_digits", 32'(n_digits), 32'd0);
        check("rst_timeout_evt", 32'(timeout_evt), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(VAZIO));
    endtask

    // driver tasks: inputs change on negedge, outputs sampled 1 after posedge
    task automatic do_cycle(input logic en, input logic kv, input logic [3:0] kc);
        enable    = en;
        key_valid = kv;
        key_code  = kc;
        @(posedge clk);
        model_step(en, kv, kc);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic press(input logic [3:0] kc);
        do_cycle(1'b1, 1'b1, kc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b1, 1'b0, 4'h0);
    endtask

    task automatic async_reset();
        rst = 1'b1;
        #1;
        check_reset_values();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        model_reset();
        #12;
        check_reset_values();
        @(negedge clk);
        rst = 1'b0;

        // 1,2,3,4 enter
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(KEY_ENTER);
        idle(3);
        // 9 shifted out
        press(4'h9); press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(KEY_ENTER);
        idle(2);
        // short entry
        press(4'h5); press(4'h6); press(KEY_ENTER);
        idle(2);
        // clear then enter
        press(4'h7); press(4'h8); press(KEY_CLEAR); press(KEY_ENTER);
        idle(2);
        // timeout fires
        press(4'h3); idle(int'(T) + 2);
        // key on the last idle cycle suppresses the timeout
        press(4'h3); idle(int'(T) - 1); press(4'h5); idle(3); press(KEY_CLEAR);
        // ignored codes do not restart the timeout
        press(4'h2); idle(4); press(4'hE); idle(int'(T));
        // enable low
        press(4'h1); press(4'h2);
        do_cycle(1'b0, 1'b1, 4'h3); do_cycle(1'b0, 1'b1, 4'h4); do_cycle(1'b0, 1'b0, 4'h0);
        press(KEY_ENTER); idle(2);
        // back-to-back enters, key in the ENVIA cycle
        press(4'h1); press(KEY_ENTER); press(KEY_ENTER); idle(2);
        press(4'h1); press(KEY_ENTER); press(4'h2); press(KEY_ENTER); idle(2);
        // enable drop during the status cycle
        press(4'h6); press(KEY_ENTER); do_cycle(1'b0, 1'b0, 4'h0); idle(2);
        // reset mid-entry and during status
        press(4'h1); press(4'h2);
        async_reset();
        idle(1);
        press(4'h4); press(KEY_ENTER);
        async_reset();
        idle(2);

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            int r;
            logic [3:0] kc;
            if ($urandom_range(0, 39) == 0) begin
                idle($urandom_range(int'(T) - 2, int'(T) + 3));
            end else begin
                r = $urandom_range(0, 9);
                if (r < 6) kc = 4'($urandom_range(0, 9));
                else if (r < 7) kc = KEY_CLEAR;
                else if (r < 8) kc = KEY_ENTER;
                else kc = 4'($urandom_range(0, 15));
                do_cycle($urandom_range(0, 19) != 0, $urandom_range(0, 2) == 0, kc);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
